lut_table_writer: RTL and testbench

//  Runtime-programmable neuron LUT: the write side of a fixed truth-table neuron.
//  - Serially loads a 2^IN_BITS x OUT_BITS truth table over a valid/ready config stream.
//  - Serves registered lookups from that table.
//  - Sits beside a layer's neuron LUTs so neuron functions can be reprogrammed without re-synthesis.

---
 rtl/lut_table_writer.sv | 131 +++++++++++++
 tb/tb_lut_table_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_table_writer.sv
// Runtime-loadable neuron truth table: serial valid/ready table load plus 1-cycle registered lookups.
// Optional feature macro: LUT_PARITY_EN (trailing parity beat checked before the table is armed).
module lut_table_writer #(
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 1,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WORD_BITS-1:0] cfg_data,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 tbl_valid,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  output logic [OUT_BITS-1:0]  out_data
);

  localparam int TBL_BITS = OUT_BITS * (2 ** IN_BITS);
  localparam int NBEATS   = TBL_BITS / WORD_BITS;
  localparam int CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

`ifdef LUT_PARITY_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ARMED} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
`endif

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [TBL_BITS-1:0] tbl;
  logic                accept;
  logic                last_beat;

  assign accept    = cfg_valid & cfg_ready;
  assign last_beat = (cnt == LAST_BEAT);

`ifdef LUT_PARITY_EN
  logic parity_ok;
  assign parity_ok = (cfg_data[0] == ^tbl);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A start pulse wins over everything else, including a beat offered in the same cycle.
  always_comb begin
    next_state = state;
    if (cfg_start) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (accept && last_beat) begin
`ifdef LUT_PARITY_EN
            next_state = CHECK;
`else
            next_state = ARMED;
`endif
          end
        end
`ifdef LUT_PARITY_EN
        CHECK: begin
          if (accept) next_state = parity_ok ? ARMED : IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_ready = 1'b0;
    tbl_valid = 1'b0;
    case (state)
      LOAD:  cfg_ready = ~cfg_start;
`ifdef LUT_PARITY_EN
      CHECK: cfg_ready = ~cfg_start;
`endif
      ARMED: tbl_valid = 1'b1;
      default: ;
    endcase
  end

  // Restarting only rewinds the beat counter; stale table bits survive until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tbl <= '0;
    end else if (cfg_start) begin
      cnt <= '0;
    end else if (state == LOAD && accept) begin
      tbl[cnt*WORD_BITS +: WORD_BITS] <= cfg_data;
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_done <= 1'b0;
    else     cfg_done <= (next_state == ARMED) && (state != ARMED);
  end

`ifdef LUT_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         cfg_err <= 1'b0;
    else if (cfg_start)                              cfg_err <= 1'b0;
    else if (state == CHECK && accept && !parity_ok) cfg_err <= 1'b1;
  end
`else
  assign cfg_err = 1'b0;
`endif

  // out_data only moves on a served lookup so it holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid & tbl_valid;
      if (in_valid && tbl_valid) out_data <= tbl[in_data*OUT_BITS +: OUT_BITS];
    end
  end

endmodule

// File: tb/tb_lut_table_writer.sv
// Self-checking bench for lut_table_writer: randomized loads/lookups against a behavioural table model.
// Lookup results are checked by a scoreboard monitor; load status outputs are checked every cycle.
module tb_lut_table_writer;

  localparam int IN_BITS   = 6;
  localparam int OUT_BITS  = 1;
  localparam int WORD_BITS = 8;
  localparam int ENTRIES   = 64;
  localparam int NBEATS    = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_start = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [WORD_BITS-1:0] cfg_data = '0;
  logic                 cfg_done;
  logic                 cfg_err;
  logic                 tbl_valid;
  logic                 in_valid = 1'b0;
  logic [IN_BITS-1:0]   in_data = '0;
  logic                 out_valid;
  logic [OUT_BITS-1:0]  out_data;

  lut_table_writer #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_BITS(WORD_BITS)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .tbl_valid(tbl_valid),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; logic data; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int done_count = 0;

  // Reference model: the table as a flat bit array plus the load progress the protocol implies.
  logic m_tbl [ENTRIES];
  bit   m_loading, m_check, m_armed, m_err, m_done;
  int   m_beat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit model_parity();
    bit p = 1'b0;
    foreach (m_tbl[i]) p ^= m_tbl[i];
    return p;
  endfunction

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 1'b0;
    m_loading = 0; m_check = 0; m_armed = 0; m_err = 0; m_done = 0; m_beat = 0;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          compare("out_valid_unexpected", out_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          compare("lookup_cycle", cyc, mon_e.cyc);
          compare($sformatf("lookup_data[%0d]", mon_e.addr), out_data, mon_e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e = sbq.pop_front();
        compare($sformatf("out_valid_missing[%0d]", mon_e.addr), out_valid, 1);
      end
    end
  end

  task automatic checkOutput();
    if (cfg_done === 1'b1) done_count++;
    compare("cfg_done", cfg_done, m_done);
    compare("tbl_valid", tbl_valid, m_armed);
    compare("cfg_err", cfg_err, m_err);
  endtask

  // One clock of stimulus; the model advances by what the posedge should do.
  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d,
                               input logic lv, input logic [5:0] la);
    bit rdy, acc;
    @(negedge clk);
    cfg_start = st; cfg_valid = v; cfg_data = d; in_valid = lv; in_data = la;
    rdy = (m_loading || m_check) && !st;
    #1 compare("cfg_ready", cfg_ready, rdy);
    if (lv && m_armed) sbq.push_back('{cyc + 1, int'(la), m_tbl[la]});
    acc = rdy && v;
    m_done = 0;
    if (st) begin
      m_loading = 1; m_check = 0; m_armed = 0; m_err = 0; m_beat = 0;
    end else if (acc && m_check) begin
      m_check = 0;
      if (d[0] == model_parity()) begin m_armed = 1; m_done = 1; end
      else m_err = 1;
    end else if (acc) begin
      for (int i = 0; i < WORD_BITS; i++) m_tbl[m_beat*WORD_BITS + i] = d[i];
      if (m_beat == NBEATS - 1) begin
        m_loading = 0;
`ifdef LUT_PARITY_EN
        m_check = 1;
`else
        m_armed = 1; m_done = 1;
`endif
      end else begin
        m_beat++;
      end
    end
    @(posedge clk);
    #1 checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 6'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    cfg_start = 0; cfg_valid = 0; in_valid = 0;
    #2 rst = 1'b1;
    model_reset();
    sbq.delete();
    #1;
    compare("rst_cfg_ready", cfg_ready, 0);
    compare("rst_cfg_done", cfg_done, 0);
    compare("rst_cfg_err", cfg_err, 0);
    compare("rst_tbl_valid", tbl_valid, 0);
    compare("rst_out_valid", out_valid, 0);
    compare("rst_out_data", out_data, 0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic loadTable(input logic [7:0] beats [NBEATS], input bit toggle);
    bit par = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 6'($urandom));
    for (int b = 0; b < NBEATS; b++) begin
      if (toggle) applyStimulus(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 6'($urandom));
      applyStimulus(1'b0, 1'b1, beats[b], 1'($urandom_range(0, 1)), 6'($urandom));
      par ^= ^beats[b];
    end
`ifdef LUT_PARITY_EN
    applyStimulus(1'b0, 1'b1, {7'($urandom), par}, 1'($urandom_range(0, 1)), 6'($urandom));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pat_a [NBEATS];
    logic [7:0] pat_ff [NBEATS];
    int d0;
    pat_a = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    foreach (pat_ff[i]) pat_ff[i] = 8'hFF;
    model_reset();
    doReset();
    idle(2);

    // Sparse pattern; first lookup lands in the cfg_done cycle.
    $display("[TB] load 0x01..0x80");
    loadTable(pat_a, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd63);
    idle(2);

    $display("[TB] same load with gapped cfg_valid");
    loadTable(pat_a, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd63);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
    idle(1);

    $display("[TB] restart after beat 3 with coincident beat, then 0xFF load");
    d0 = done_count;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 6'd0);
    for (int b = 0; b < NBEATS; b++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 6'd0);
`ifdef LUT_PARITY_EN
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 6'd0);
`endif
    idle(3);
    compare("single_cfg_done", done_count - d0, 1);

    $display("[TB] back-to-back lookups 0..63");
    for (int a = 0; a < ENTRIES; a++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'(a));
    idle(1);
    compare("out_valid_idle", out_valid, 0);
    compare("out_data_hold", out_data, m_tbl[63]);

    $display("[TB] reset in the middle of a reload");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 6'd7);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1, 6'd8);
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 6'd0);
    doReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd5);
    compare("reset_lookup_out_valid", out_valid, 0);
    idle(1);

    $display("[TB] randomized traffic");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 6'($urandom));
    idle(2);

`ifdef LUT_PARITY_EN
    $display("[TB] parity error then good reload");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    for (int b = 0; b < NBEATS; b++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 6'd0);
    idle(2);
    compare("parity_err_sticky", cfg_err, 1);
    compare("parity_err_tbl_valid", tbl_valid, 0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    for (int b = 0; b < NBEATS; b++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 6'd9);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 6'd10);
    idle(2);
`endif

    compare("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
